cache_refill_engine: RTL and testbench
======================================

CACHE_REFILL_ENGINE -- requirements
Module: cache_refill_engine

Interface
REQ-001 Parameter: LINE_SIZE_BYTES, 64, cache line size in bytes.
REQ-002 Parameter: DATA_WIDTH, 32, memory bus word width in bits.
REQ-003 Parameter: ADDRESS_WIDTH, 32, byte address width.
REQ-004 Parameter: OFFSET_BITS, 6, line offset width (log2 of LINE_SIZE_BYTES).
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 i_req_valid  in  1  miss request present.
REQ-009 o_req_ready  out  1  engine idle and able to accept a request.
REQ-010 i_req_fill_addr  in  ADDRESS_WIDTH  line address to fetch; low OFFSET_BITS ignored.
REQ-011 i_req_wb  in  1  victim is dirty and needs write-back.
REQ-012 i_req_wb_addr  in  ADDRESS_WIDTH  victim line address; low OFFSET_BITS ignored.
REQ-013 i_req_wb_data  in  LINE_SIZE_BYTES*8  victim line data.
REQ-014 o_rsp_valid  out  1  filled line available.
REQ-015 i_rsp_ready  in  1  controller accepts the filled line.
REQ-016 o_rsp_addr  out  ADDRESS_WIDTH  line-aligned fill address.
REQ-017 o_rsp_data  out  LINE_SIZE_BYTES*8  assembled line.
REQ-018 o_mem_valid / i_mem_ready  out / in  1 / 1  memory command handshake.
REQ-019 o_mem_we  out  1  1 = write command, 0 = read command.
REQ-020 o_mem_addr / o_mem_wdata  out  ADDRESS_WIDTH / DATA_WIDTH  command address and write data.
REQ-021 i_mem_rvalid / i_mem_rdata  in  1 / DATA_WIDTH  read return word.

Function
REQ-022 WORDS = LINE_SIZE_BYTES*8/DATA_WIDTH (16 at defaults); word k SHALL occupy bits [DATA_WIDTH*k +: DATA_WIDTH] and address base + k*(DATA_WIDTH/8).
REQ-023 FSM states SHALL be IDLE, WB, FILL_REQ, FILL_WAIT, RESP.
REQ-024 o_req_ready SHALL be 1 only in IDLE; request is accepted on i_req_valid & o_req_ready, capturing all req fields.
REQ-025 On accept: i_req_wb=1 -> WB with word counter 0; else -> FILL_REQ with counter 0.
REQ-026 WB: o_mem_valid=1, o_mem_we=1, addr/wdata = word k of victim; on i_mem_ready counter increments; after word WORDS-1 is accepted -> FILL_REQ with counter cleared.
REQ-027 FILL_REQ: o_mem_valid=1, o_mem_we=0, addr = fill word k; on i_mem_ready -> FILL_WAIT.
REQ-028 FILL_WAIT: o_mem_valid=0; on i_mem_rvalid, i_mem_rdata is stored in word k; if k = WORDS-1 -> RESP, else k+1 and -> FILL_REQ.
REQ-029 Only one read SHALL be outstanding; i_mem_rvalid in any state other than FILL_WAIT SHALL be ignored.
REQ-030 o_mem_addr, o_mem_we and o_mem_wdata SHALL stay stable while o_mem_valid=1 and i_mem_ready=0.
REQ-031 RESP: o_rsp_valid=1, data/addr stable; on i_rsp_ready -> IDLE; request acceptance is possible no earlier than the following cycle.
REQ-032 o_rsp_addr and o_mem_addr SHALL have low OFFSET_BITS forced to 0 at line level, then add word byte offset.
REQ-033 Counter SHALL be clog2(WORDS) bits and never wrap outside the final-word transitions above.

Reset
REQ-034 rst SHALL immediately force IDLE, counter 0, line buffer 0, o_req_ready=1 after release, o_rsp_valid=0, o_mem_valid=0, o_mem_we=0, all address/data outputs 0.
REQ-035 Reset mid-transfer SHALL abort it with no further memory commands; returns in flight are discarded.

Structure
REQ-036 Package cache_pkg SHALL hold LINE_SIZE_BYTES, DATA_WIDTH, ADDRESS_WIDTH, OFFSET_BITS, WORDS and the FSM state type.
REQ-037 One sub-module, fill_line_buffer (WORDS x DATA_WIDTH register with indexed word write, full-line read), SHALL be instantiated.

Verification
REQ-038 Clean fill: wb=0, fill_addr 0x0000_1040, mem ready=1, rvalid 1 cycle after accept, rdata = 0xA000_0000+k -> 16 reads addr 0x1040..0x107C, o_rsp_data word k = 0xA000_0000+k, o_rsp_addr 0x1040.
REQ-039 Dirty victim: wb=1, wb_addr 0x2000, word k = k -> 16 writes 0x2000..0x203C data 0..15 strictly before first read command.
REQ-040 Backpressure: i_mem_ready low 3 cycles per command -> command fields unchanged while stalled, result identical to REQ-038.
REQ-041 Response stall: i_rsp_ready low 5 cycles -> o_rsp_valid held, data stable, o_req_ready=0 throughout.
REQ-042 Spurious rvalid in IDLE and WB -> ignored, buffer unchanged.
REQ-043 rst asserted after 7th read accept -> all outputs 0 asynchronously, next request fills cleanly from word 0.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared constants and the refill FSM state type for the cache refill engine.
//   LINE_SIZE_BYTES : cache line size in bytes
//   DATA_WIDTH      : memory bus word width in bits
//   ADDRESS_WIDTH   : byte address width
//   OFFSET_BITS     : log2(LINE_SIZE_BYTES), width of the in-line byte offset
//   WORDS           : bus words per cache line
//   state_t         : refill engine FSM states
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int LINE_SIZE_BYTES = 64;
    localparam int DATA_WIDTH      = 32;
    localparam int ADDRESS_WIDTH   = 32;
    localparam int OFFSET_BITS     = 6;
    localparam int WORDS           = LINE_SIZE_BYTES * 8 / DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL_REQ,
        FILL_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/fill_line_buffer.sv
// -----------------------------------------------------------------------------
// fill_line_buffer
// WORDS x DATA_WIDTH register that assembles one cache line from individual
// bus words and presents the whole line in parallel.
//   clk, rst : clock, asynchronous active-high reset (clears the line)
//   we       : write enable for one word
//   idx      : word index to write
//   wdata    : word value
//   line     : full assembled line, word k at [DATA_WIDTH*k +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module fill_line_buffer #(
    parameter int WORDS      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = $clog2(WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [IDX_WIDTH-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [WORDS*DATA_WIDTH-1:0] line
);

    logic [WORDS*DATA_WIDTH-1:0] line_q;

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every register samples its inputs as they were before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (we) begin
            line_q[int'(idx) * DATA_WIDTH +: DATA_WIDTH] <= wdata;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/cache_refill_engine.sv
// -----------------------------------------------------------------------------
// cache_refill_engine
// Services one cache miss at a time: optionally writes the dirty victim line
// back word by word, then fetches the new line one word at a time (a single
// read outstanding) and hands the assembled line to the cache controller.
//   clk, rst                      : clock, asynchronous active-high reset
//   i_req_valid / o_req_ready     : miss request handshake (ready only in IDLE)
//   i_req_fill_addr               : line to fetch (offset bits ignored)
//   i_req_wb, i_req_wb_addr       : victim dirty flag and victim line address
//   i_req_wb_data                 : victim line data
//   o_rsp_valid / i_rsp_ready     : filled line handshake
//   o_rsp_addr, o_rsp_data        : line-aligned fill address, assembled line
//   o_mem_valid / i_mem_ready     : memory command handshake
//   o_mem_we, o_mem_addr          : command type (1 = write) and byte address
//   o_mem_wdata                   : write data
//   i_mem_rvalid, i_mem_rdata     : read return
// -----------------------------------------------------------------------------
module cache_refill_engine #(
    parameter int LINE_SIZE_BYTES = cache_pkg::LINE_SIZE_BYTES,
    parameter int DATA_WIDTH      = cache_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH   = cache_pkg::ADDRESS_WIDTH,
    parameter int OFFSET_BITS     = cache_pkg::OFFSET_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0]     i_req_fill_addr,
    input  logic                         i_req_wb,
    input  logic [ADDRESS_WIDTH-1:0]     i_req_wb_addr,
    input  logic [LINE_SIZE_BYTES*8-1:0] i_req_wb_data,
    output logic                         o_rsp_valid,
    input  logic                         i_rsp_ready,
    output logic [ADDRESS_WIDTH-1:0]     o_rsp_addr,
    output logic [LINE_SIZE_BYTES*8-1:0] o_rsp_data,
    output logic                         o_mem_valid,
    input  logic                         i_mem_ready,
    output logic                         o_mem_we,
    output logic [ADDRESS_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]        o_mem_wdata,
    input  logic                         i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]        i_mem_rdata
);

    import cache_pkg::state_t;
    import cache_pkg::IDLE;
    import cache_pkg::WB;
    import cache_pkg::FILL_REQ;
    import cache_pkg::FILL_WAIT;
    import cache_pkg::RESP;

    localparam int WORDS          = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
    localparam int CNT_WIDTH      = $clog2(WORDS);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0]     LAST_WORD   = CNT_WIDTH'(WORDS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK =
        ADDRESS_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

    state_t                          state_q, state_d;
    logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0]        fill_base_q, wb_base_q;
    logic [LINE_SIZE_BYTES*8-1:0]    victim_q;
    logic [ADDRESS_WIDTH-1:0]        word_offset;
    logic                            accept;
    logic                            buf_we;

    assign word_offset = ADDRESS_WIDTH'(cnt_q) * ADDRESS_WIDTH'(BYTES_PER_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Line bases are stored already aligned so every later address is base + offset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_base_q <= '0;
            wb_base_q   <= '0;
        end else if (accept) begin
            fill_base_q <= i_req_fill_addr & ~OFFSET_MASK;
            wb_base_q   <= i_req_wb_addr & ~OFFSET_MASK;
        end
    end

    // NOTE: the victim line is a wide data-only register and is left out of
    // reset; its words only reach o_mem_wdata while in WB, after a capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            victim_q <= i_req_wb_data;
        end
    end

    // NOTE: every signal written here gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        buf_we      = 1'b0;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_mem_valid = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;

        case (state_q)
            IDLE: begin
                // Gated by rst so every output reads 0 while reset is held.
                o_req_ready = !rst;
                if (i_req_valid && !rst) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = i_req_wb ? WB : FILL_REQ;
                end
            end
            WB: begin
                o_mem_valid = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = wb_base_q + word_offset;
                o_mem_wdata = victim_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH];
                if (i_mem_ready) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = FILL_REQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FILL_REQ: begin
                o_mem_valid = 1'b1;
                o_mem_addr  = fill_base_q + word_offset;
                if (i_mem_ready) begin
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                // The only state that listens to read returns.
                if (i_mem_rvalid) begin
                    buf_we = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = FILL_REQ;
                    end
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    fill_line_buffer #(
        .WORDS      (WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (CNT_WIDTH)
    ) u_line_buffer (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .idx   (cnt_q),
        .wdata (i_mem_rdata),
        .line  (o_rsp_data)
    );

    assign o_rsp_addr = fill_base_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_engine
// Scoreboard bench: each request pushes its expected memory command sequence
// and expected filled line into queues; a monitor pops and compares whenever
// the engine issues a command or presents a line. A small memory model answers
// reads with rd_base + word index.
// -----------------------------------------------------------------------------
module tb_cache_refill_engine;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] line;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req_valid;
    logic         o_req_ready;
    logic [31:0]  i_req_fill_addr;
    logic         i_req_wb;
    logic [31:0]  i_req_wb_addr;
    logic [511:0] i_req_wb_data;
    logic         o_rsp_valid;
    logic         i_rsp_ready;
    logic [31:0]  o_rsp_addr;
    logic [511:0] o_rsp_data;
    logic         o_mem_valid;
    logic         i_mem_ready;
    logic         o_mem_we;
    logic [31:0]  o_mem_addr;
    logic [31:0]  o_mem_wdata;
    logic         i_mem_rvalid;
    logic [31:0]  i_mem_rdata;

    cache_refill_engine dut (
        .clk             (clk),
        .rst             (rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_fill_addr (i_req_fill_addr),
        .i_req_wb        (i_req_wb),
        .i_req_wb_addr   (i_req_wb_addr),
        .i_req_wb_data   (i_req_wb_data),
        .o_rsp_valid     (o_rsp_valid),
        .i_rsp_ready     (i_rsp_ready),
        .o_rsp_addr      (o_rsp_addr),
        .o_rsp_data      (o_rsp_data),
        .o_mem_valid     (o_mem_valid),
        .i_mem_ready     (i_mem_ready),
        .o_mem_we        (o_mem_we),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wdata     (o_mem_wdata),
        .i_mem_rvalid    (i_mem_rvalid),
        .i_mem_rdata     (i_mem_rdata)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    // Environment knobs.
    int          ready_mode = 0;   // 0 always ready, 1 random, 2 three-cycle stall
    int          rd_lat     = 0;   // extra cycles before a read returns
    int          rsp_stall  = 0;   // cycles i_rsp_ready stays low
    bit          spur_en    = 0;   // inject rvalid when no read is outstanding
    logic [31:0] rd_base    = '0;

    // Memory model state.
    bit          rd_pend = 0;
    int          rd_wait = 0;
    logic [31:0] rd_addr = '0;
    int          read_hs = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input int value);
        n_checks++;
        n_fail++;
        $display("FAIL %s: observed %0d", name, value);
    endtask

    // i_mem_ready driver
    initial begin : mem_ready_drv
        int stall_cnt = 0;
        i_mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) begin
                if (o_mem_valid && stall_cnt == 3) begin
                    i_mem_ready = 1'b1;
                    stall_cnt   = 0;
                end else if (o_mem_valid) begin
                    i_mem_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    i_mem_ready = 1'b0;
                    stall_cnt   = 0;
                end
            end else if (ready_mode == 1) begin
                i_mem_ready = 1'($urandom_range(0, 1));
            end else begin
                i_mem_ready = 1'b1;
            end
        end
    end

    // Read-return responder (one read outstanding at most).
    initial begin : responder
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            i_mem_rvalid = 1'b0;
            if (rd_pend && rd_wait == 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = rd_base + {28'd0, rd_addr[5:2]};
                rd_pend      = 0;
            end else if (rd_pend) begin
                rd_wait--;
            end else if (spur_en && $urandom_range(0, 2) == 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = $urandom;
            end
        end
    end

    // i_rsp_ready driver
    initial begin : rsp_ready_drv
        int cnt = 0;
        i_rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (o_rsp_valid && cnt >= rsp_stall) begin
                i_rsp_ready = 1'b1;
            end else if (o_rsp_valid) begin
                i_rsp_ready = 1'b0;
                cnt++;
            end else begin
                i_rsp_ready = 1'b0;
                cnt         = 0;
            end
        end
    end

    // Monitor: pops expectations on every handshake and checks hold behaviour.
    initial begin : monitor
        bit           prev_stall = 0;
        bit           prev_hold  = 0;
        logic         p_we;
        logic [31:0]  p_addr, p_wdata, p_raddr;
        logic [511:0] p_rdata;
        cmd_t         ec;
        rsp_t         er;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                prev_hold  = 0;
                continue;
            end
            if (prev_stall) begin
                check("mem_valid_held", o_mem_valid, 1'b1);
                check("mem_we_held", o_mem_we, p_we);
                check("mem_addr_held", o_mem_addr, p_addr);
                check("mem_wdata_held", o_mem_wdata, p_wdata);
            end
            if (o_mem_valid && i_mem_ready) begin
                if (cmd_q.size() == 0) begin
                    fail_event("unexpected_mem_cmd_addr", int'(o_mem_addr));
                end else begin
                    ec = cmd_q.pop_front();
                    check("mem_we", o_mem_we, ec.we);
                    check("mem_addr", o_mem_addr, ec.addr);
                    if (ec.we) check("mem_wdata", o_mem_wdata, ec.wdata);
                end
                if (!o_mem_we) begin
                    rd_pend = 1;
                    rd_wait = rd_lat;
                    rd_addr = o_mem_addr;
                    read_hs++;
                end
            end
            prev_stall = o_mem_valid && !i_mem_ready;
            p_we    = o_mem_we;
            p_addr  = o_mem_addr;
            p_wdata = o_mem_wdata;

            if (prev_hold) begin
                check("rsp_valid_held", o_rsp_valid, 1'b1);
                check("rsp_addr_held", o_rsp_addr, p_raddr);
                check("rsp_data_held", o_rsp_data, p_rdata);
            end
            if (o_rsp_valid) begin
                check("req_ready_low_in_resp", o_req_ready, 1'b0);
                if (i_rsp_ready) begin
                    if (rsp_q.size() == 0) begin
                        fail_event("unexpected_rsp_addr", int'(o_rsp_addr));
                    end else begin
                        er = rsp_q.pop_front();
                        check("rsp_addr", o_rsp_addr, er.addr);
                        check("rsp_data", o_rsp_data, er.line);
                    end
                end
            end
            prev_hold = o_rsp_valid && !i_rsp_ready;
            p_raddr   = o_rsp_addr;
            p_rdata   = o_rsp_data;
        end
    end

    // Reference model: a miss is an optional 16-word victim write-back followed
    // by 16 reads of the aligned fill line; the line returned is what memory sent.
    task automatic issue_req(input logic [31:0] fill_addr, input logic wb,
                             input logic [31:0] wb_addr, input logic [511:0] wb_data,
                             input logic [31:0] base);
        logic [31:0]  fb, vb;
        logic [511:0] line;
        bit           got;
        fb      = {fill_addr[31:6], 6'd0};
        vb      = {wb_addr[31:6], 6'd0};
        rd_base = base;
        if (wb) begin
            for (int k = 0; k < 16; k++)
                cmd_q.push_back('{we: 1'b1, addr: vb + 32'(4 * k), wdata: wb_data[32*k +: 32]});
        end
        for (int k = 0; k < 16; k++) begin
            cmd_q.push_back('{we: 1'b0, addr: fb + 32'(4 * k), wdata: 32'd0});
            line[32*k +: 32] = base + 32'(k);
        end
        rsp_q.push_back('{addr: fb, line: line});

        @(posedge clk);
        #1;
        i_req_valid     = 1'b1;
        i_req_fill_addr = fill_addr;
        i_req_wb        = wb;
        i_req_wb_addr   = wb_addr;
        i_req_wb_data   = wb_data;
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (o_req_ready) got = 1;
        end
        @(posedge clk);
        #1;
        i_req_valid     = 1'b0;
        i_req_fill_addr = $urandom;
        i_req_wb        = 1'($urandom_range(0, 1));
        i_req_wb_addr   = $urandom;
        i_req_wb_data   = {16{$urandom}};
        if (!got) fail_event("req_accept_timeout", 50);
    endtask

    task automatic wait_done();
        int c = 0;
        while (rsp_q.size() != 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (rsp_q.size() != 0) begin
            fail_event("fill_timeout_pending_cmds", cmd_q.size());
            cmd_q.delete();
            rsp_q.delete();
        end
    endtask

    task automatic run_txn(input logic [31:0] fill_addr, input logic wb,
                           input logic [31:0] wb_addr, input logic [511:0] wb_data,
                           input logic [31:0] base);
        issue_req(fill_addr, wb, wb_addr, wb_data, base);
        wait_done();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, o_req_ready, 1'b0);
        check({tag, "_rsp_valid"}, o_rsp_valid, 1'b0);
        check({tag, "_rsp_addr"}, o_rsp_addr, 32'd0);
        check({tag, "_rsp_data"}, o_rsp_data, 512'd0);
        check({tag, "_mem_valid"}, o_mem_valid, 1'b0);
        check({tag, "_mem_we"}, o_mem_we, 1'b0);
        check({tag, "_mem_addr"}, o_mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [511:0] vdata;
        int           target;

        rst             = 1'b1;
        i_req_valid     = 1'b0;
        i_req_fill_addr = '0;
        i_req_wb        = 1'b0;
        i_req_wb_addr   = '0;
        i_req_wb_data   = '0;

        #2;
        check_all_zero("reset");
        #21;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", o_req_ready, 1'b1);
        check("post_reset_mem_valid", o_mem_valid, 1'b0);

        // Clean fill, zero-latency returns.
        run_txn(32'h0000_1040, 1'b0, 32'h0, 512'd0, 32'hA000_0000);

        // Dirty victim: 16 writes strictly before the first read.
        for (int k = 0; k < 16; k++) vdata[32*k +: 32] = 32'(k);
        run_txn(32'h0000_3000, 1'b1, 32'h0000_2000, vdata, 32'h5500_0000);

        // Memory backpressure: three stall cycles per command.
        ready_mode = 2;
        run_txn(32'h0000_1040, 1'b0, 32'h0, 512'd0, 32'hA000_0000);
        ready_mode = 0;

        // Response stall of five cycles.
        rsp_stall = 5;
        run_txn(32'h0000_1047, 1'b0, 32'h0, 512'd0, 32'hA000_0000);
        rsp_stall = 0;

        // Spurious read returns in IDLE and during write-back.
        spur_en = 1;
        for (int k = 0; k < 16; k++) vdata[32*k +: 32] = $urandom;
        repeat (6) @(posedge clk);
        run_txn(32'h0000_4abc, 1'b1, 32'h0000_8f13, vdata, 32'h1234_0000);
        spur_en = 0;

        // Reset after the 7th read command is accepted.
        target = read_hs + 7;
        issue_req(32'h0000_6000, 1'b0, 32'h0, 512'd0, 32'hC000_0000);
        for (int c = 0; c < 500 && read_hs < target; c++) @(negedge clk);
        if (read_hs < target) fail_event("seventh_read_timeout", read_hs);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        cmd_q.delete();
        rsp_q.delete();
        rd_pend = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("reset_release_req_ready", o_req_ready, 1'b1);
        repeat (6) @(negedge clk);
        run_txn(32'h0000_7040, 1'b0, 32'h0, 512'd0, 32'hB000_0000);

        // Randomized traffic.
        for (int i = 0; i < 20; i++) begin
            ready_mode = $urandom_range(0, 2);
            rd_lat     = $urandom_range(0, 3);
            rsp_stall  = $urandom_range(0, 3);
            spur_en    = 1'($urandom_range(0, 1));
            for (int k = 0; k < 16; k++) vdata[32*k +: 32] = $urandom;
            run_txn($urandom, 1'($urandom_range(0, 1)), $urandom, vdata, $urandom);
        end
        ready_mode = 0;
        spur_en    = 0;

        repeat (10) @(negedge clk);
        check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
        check("idle_req_ready", o_req_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
